// File: rtl/pulse_width_meter_pkg.sv
// rtl/pulse_width_meter_pkg.sv - shared state encoding and default sizing for the pulse width meter
package pulse_width_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } pwm_state_t;

    localparam int CNT_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/pwm_result_fifo.sv
// rtl/pwm_result_fifo.sv - result queue with stream-style write/read sides
module pwm_result_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_tdata,
    input  logic         wr_tvalid,
    output logic         wr_tready,
    output logic [W-1:0] rd_tdata,
    output logic         rd_tvalid,
    input  logic         rd_tready
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         empty, full, push, pop;

    // Extra pointer MSB tells a full queue apart from an empty one.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_tvalid = !empty;
        pop       = rd_tvalid && rd_tready;
        wr_tready = !full || pop;
        push      = wr_tvalid && wr_tready;
        rd_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_tdata;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high-time between edge strobes and queues the results
module pulse_width_meter #(
    parameter int CNT_W = pulse_width_meter_pkg::CNT_W_DEFAULT,
    parameter int DEPTH = pulse_width_meter_pkg::DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rising_edge_pulse,
    input  logic             falling_edge_pulse,
    output logic [CNT_W-1:0] width_out,
    output logic             width_sat,
    output logic             width_valid,
    input  logic             width_ready,
    output logic             measuring,
    output logic [7:0]       drop_count,
    output logic             proto_err
);

    import pulse_width_meter_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [7:0]       drop_q, drop_d;
    logic             err_q, err_d;
    logic             cnt_at_max;
    logic             push_tvalid, push_tready;
    logic [CNT_W:0]   push_tdata;
    logic [CNT_W:0]   head_tdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        err_d       = err_q;
        drop_d      = drop_q;
        push_tvalid = 1'b0;
        cnt_at_max  = (cnt_q == CNT_MAX);
        // The counter lags the true width by one, hence the +1 on push.
        push_tdata  = {sat_q | cnt_at_max, cnt_at_max ? CNT_MAX : cnt_q + CNT_W'(1)};

        if (rising_edge_pulse && falling_edge_pulse) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rising_edge_pulse) begin
                        state_d = ST_MEAS;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                ST_MEAS: begin
                    if (rising_edge_pulse) begin
                        cnt_d = '0;
                        sat_d = 1'b0;
                        err_d = 1'b1;
                    end else if (falling_edge_pulse) begin
                        push_tvalid = 1'b1;
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        sat_d       = 1'b0;
                    end else if (cnt_at_max) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (push_tvalid && !push_tready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    pwm_result_fifo #(
        .W     (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_tdata  (push_tdata),
        .wr_tvalid (push_tvalid),
        .wr_tready (push_tready),
        .rd_tdata  (head_tdata),
        .rd_tvalid (width_valid),
        .rd_tready (width_ready)
    );

    assign width_out  = head_tdata[CNT_W-1:0];
    assign width_sat  = head_tdata[CNT_W];
    assign measuring  = (state_q == ST_MEAS);
    assign drop_count = drop_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - bench for pulse_width_meter with 16-bit and 4-bit counter instances
module tb_pulse_width_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rise, fall, ready;

    logic [15:0] a_width;
    logic        a_sat, a_valid, a_meas, a_err;
    logic [7:0]  a_drop;
    logic [3:0]  b_width;
    logic        b_sat, b_valid, b_meas, b_err;
    logic [7:0]  b_drop;

    pulse_width_meter #(.CNT_W(16), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rising_edge_pulse(rise), .falling_edge_pulse(fall),
        .width_out(a_width), .width_sat(a_sat), .width_valid(a_valid), .width_ready(ready),
        .measuring(a_meas), .drop_count(a_drop), .proto_err(a_err)
    );

    pulse_width_meter #(.CNT_W(4), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rising_edge_pulse(rise), .falling_edge_pulse(fall),
        .width_out(b_width), .width_sat(b_sat), .width_valid(b_valid), .width_ready(ready),
        .measuring(b_meas), .drop_count(b_drop), .proto_err(b_err)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic rst, rise, fall, ready;
        logic valid;
        int   width;
        logic meas, err;
    } vec_t;

    vec_t vecs[17];

    // Reference model: results kept as unbounded widths computed from edge timestamps.
    int q[$];
    bit m_meas, m_err;
    int m_t0, m_drop, m_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rise = 1'b0; fall = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input int w);
        rise = 1'b1;
        tick();
        rise = 1'b0;
        repeat (w - 1) tick();
        fall = 1'b1;
        tick();
        fall = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit ri, input bit fa, input bit rd);
        bit pushing;
        int w;
        pushing = 1'b0;
        w = 0;
        if (r) begin
            q.delete();
            m_meas = 1'b0;
            m_err  = 1'b0;
            m_drop = 0;
        end else begin
            if (q.size() > 0 && rd) void'(q.pop_front());
            if (ri && fa) begin
                m_err = 1'b1;
                if (m_meas) m_t0++;   // frozen cycle does not count toward the width
            end else if (ri) begin
                if (m_meas) m_err = 1'b1;
                m_meas = 1'b1;
                m_t0   = m_t;
            end else if (fa && m_meas) begin
                m_meas  = 1'b0;
                pushing = 1'b1;
                w       = m_t - m_t0;
            end
            if (pushing) begin
                if (q.size() < 4) q.push_back(w);
                else if (m_drop < 255) m_drop++;
            end
        end
        m_t++;
    endtask

    function automatic logic [31:0] expect_pack(input int maxw, input int cw);
        logic        v, s;
        int          h;
        logic [15:0] wv;
        v  = (q.size() > 0);
        h  = v ? q[0] : 0;
        s  = v && (h > maxw);
        wv = 16'((h > maxw) ? maxw : h);
        if (cw == 4) wv = wv & 16'h000f;
        return {4'b0, v, s, wv, m_meas, m_err, 8'(m_drop)};
    endfunction

    initial begin
        int exp_list[4];
        logic stall;
        logic [31:0] act_a, act_b;

        rst = 1'b1; rise = 1'b0; fall = 1'b0; ready = 1'b1;

        //              rst rise fall rdy valid width meas err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst; rise = vecs[i].rise; fall = vecs[i].fall; ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_width", i), 32'(a_width), vecs[i].width);
            chk($sformatf("vec%0d_meas", i),  32'(a_meas),  32'(vecs[i].meas));
            chk($sformatf("vec%0d_err", i),   32'(a_err),   32'(vecs[i].err));
        end
        rst = 1'b0; rise = 1'b0; fall = 1'b0;
        chk("reset_drop", 32'(a_drop), 0);

        // Saturation boundary on the 4-bit instance.
        do_reset();
        ready = 1'b1;
        pulse(20);
        chk("sat20_b_width", 32'(b_width), 15);
        chk("sat20_b_sat",   32'(b_sat), 1);
        chk("sat20_a_width", 32'(a_width), 20);
        chk("sat20_a_sat",   32'(a_sat), 0);
        pulse(15);
        chk("w15_b_width", 32'(b_width), 15);
        chk("w15_b_sat",   32'(b_sat), 0);
        pulse(16);
        chk("w16_b_width", 32'(b_width), 15);
        chk("w16_b_sat",   32'(b_sat), 1);

        // Overflow: five results into a four-entry queue with no consumer.
        do_reset();
        ready = 1'b0;
        for (int w = 2; w <= 6; w++) pulse(w);
        chk("ovf_drop",  32'(a_drop), 1);
        chk("ovf_drop_b", 32'(b_drop), 1);
        chk("ovf_valid", 32'(a_valid), 1);
        repeat (3) tick();
        chk("ovf_hold_width", 32'(a_width), 2);
        ready = 1'b1;
        exp_list = '{2, 3, 4, 5};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_drain%0d", k), 32'(a_width), exp_list[k]);
            tick();
        end
        chk("ovf_empty", 32'(a_valid), 0);

        // Full queue: push and pop on the same edge.
        do_reset();
        ready = 1'b0;
        for (int w = 2; w <= 5; w++) pulse(w);
        rise = 1'b1; tick(); rise = 1'b0;
        tick();
        fall = 1'b1; ready = 1'b1; tick(); fall = 1'b0;
        chk("fullpp_drop", 32'(a_drop), 0);
        chk("fullpp_head", 32'(a_width), 3);
        exp_list = '{3, 4, 5, 2};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fullpp_drain%0d", k), 32'(a_width), exp_list[k]);
            tick();
        end
        chk("fullpp_empty", 32'(a_valid), 0);

        // Reset in the middle of a measurement.
        do_reset();
        ready = 1'b1;
        rise = 1'b1; tick(); rise = 1'b0;
        repeat (2) tick();
        chk("rstmeas_meas_before", 32'(a_meas), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmeas_meas_after", 32'(a_meas), 0);
        fall = 1'b1; tick(); fall = 1'b0;
        chk("rstmeas_valid", 32'(a_valid), 0);
        chk("rstmeas_meas",  32'(a_meas), 0);
        chk("rstmeas_err",   32'(a_err), 0);
        rst = 1'b1; rise = 1'b1; tick(); rst = 1'b0; rise = 1'b0;
        chk("rst_strobe_meas", 32'(a_meas), 0);

        // Re-trigger during a measurement.
        do_reset();
        ready = 1'b1;
        rise = 1'b1; tick(); rise = 1'b0;
        tick();
        rise = 1'b1; tick(); rise = 1'b0;
        tick();
        fall = 1'b1; tick(); fall = 1'b0;
        chk("retrig_err",   32'(a_err), 1);
        chk("retrig_valid", 32'(a_valid), 1);
        chk("retrig_width", 32'(a_width), 2);
        tick();
        chk("retrig_single", 32'(a_valid), 0);

        // Randomized run against the reference model.
        do_reset();
        q.delete(); m_meas = 0; m_err = 0; m_drop = 0; m_t0 = 0; m_t = 0;
        stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            rise = ($urandom_range(0, 9) == 0);
            fall = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) stall = ~stall;
            ready = !stall && ($urandom_range(0, 1) == 1);
            model_step(rst, rise, fall, ready);
            tick();
            act_a = {4'b0, a_valid, a_sat, a_width, a_meas, a_err, a_drop};
            act_b = {4'b0, b_valid, b_sat, 12'b0, b_width, b_meas, b_err, b_drop};
            chk($sformatf("rand_a_%0d", n), act_a, expect_pack(65535, 16));
            chk($sformatf("rand_b_%0d", n), act_b, expect_pack(15, 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of measured high-time and of the internal counter.
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rising_edge_pulse  input  1  one-cycle strobe marking a 0->1 edge of the monitored signal.
REQ-006 SHALL have port falling_edge_pulse  input  1  one-cycle strobe marking a 1->0 edge.
REQ-007 SHALL have port width_out  output  CNT_W  measured high-time of the FIFO head entry, in clk cycles.
REQ-008 SHALL have port width_sat  output  1  head entry saturated (true width > 2^CNT_W-1).
REQ-009 SHALL have port width_valid  output  1  FIFO non-empty; head entry presented.
REQ-010 SHALL have port width_ready  input  1  consumer accepts head when width_valid & width_ready.
REQ-011 SHALL have port measuring  output  1  high while state is MEAS.
REQ-012 SHALL have port drop_count  output  8  results lost to FIFO full, saturating at 255.
REQ-013 SHALL have port proto_err  output  1  sticky; set on any protocol violation (REQ-019, REQ-020).

Function
REQ-014 SHALL implement a two-state FSM, IDLE and MEAS.
REQ-015 IDLE + rising_edge_pulse -> MEAS, counter loaded with 0.
REQ-016 In MEAS, counter SHALL increment by 1 each cycle without a falling pulse, holding at 2^CNT_W-1 and setting an internal sat bit.
REQ-017 MEAS + falling_edge_pulse -> IDLE, pushing {counter+1 (saturating), sat} into the FIFO; a rise at cycle t0 and fall at cycle t1 yields width t1-t0.
REQ-018 IDLE + falling_edge_pulse SHALL be ignored, no push, no error.
REQ-019 MEAS + rising_edge_pulse SHALL restart measurement (counter to 0, sat cleared), discard the open measurement and set proto_err.
REQ-020 Both strobes in the same cycle SHALL be ignored entirely (state, counter unchanged) and set proto_err.
REQ-021 A pushed result SHALL appear at width_out with width_valid high on the cycle after the falling pulse when the FIFO was empty (latency 1).
REQ-022 Push when FIFO full and no pop that cycle SHALL drop the result and increment drop_count (saturating).
REQ-023 Push and pop in the same cycle when full SHALL both succeed; no drop.
REQ-024 Push and pop in the same cycle when empty SHALL NOT bypass; the entry becomes visible next cycle.
REQ-025 width_out/width_sat SHALL remain stable while width_valid is high and width_ready is low.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-027 rst high at a clk edge SHALL force state IDLE, counter 0, sat 0, FIFO empty, width_valid 0, width_out 0, width_sat 0, measuring 0, drop_count 0, proto_err 0.
REQ-028 Reset during MEAS SHALL discard the open measurement; a falling pulse in the first cycle after reset SHALL be ignored per REQ-018.
REQ-029 Strobes asserted while rst is high SHALL have no effect.

Structure
REQ-030 Package pulse_width_meter_pkg SHALL hold the FSM state encoding (IDLE=0, MEAS=1) and default CNT_W/DEPTH constants.
REQ-031 The result buffer SHALL be a sub-module named pwm_result_fifo (width CNT_W+1, depth DEPTH, valid/ready on read side).

Verification
REQ-032 Rise at cycle 10, fall at cycle 13, ready=1 -> width_valid high at cycle 14, width_out=3, width_sat=0, popped same cycle.
REQ-033 CNT_W=4, rise then fall 20 cycles later -> width_out=15, width_sat=1.
REQ-034 ready=0, five complete pulses of widths 2,3,4,5,6 -> FIFO holds 2,3,4,5 in order, drop_count=1; raising ready drains them in order.
REQ-035 FIFO full with ready=1 and a falling pulse in the same cycle -> head popped, new entry stored, drop_count unchanged.
REQ-036 rst asserted 3 cycles into MEAS, then a falling pulse -> no result, width_valid=0, measuring=0.
REQ-037 Rise during MEAS, then a fall 2 cycles later -> proto_err=1, one result with width_out=2.
